// File: rtl/nonce_sweep_scheduler_if.sv
// Job, message-block and result-return signals between the nonce sweep
// scheduler (slave) and its surroundings (master: job source plus hash pipeline).
interface nonce_sweep_scheduler_if #(
    parameter int WORD_NUM     = 16,
    parameter int DATA_WID     = 32,
    parameter int MAX_INFLIGHT = 128
);
    localparam int INF_W = $clog2(MAX_INFLIGHT) + 1;

    logic [3*DATA_WID-1:0]        iv_job_data;
    logic [DATA_WID-1:0]          iv_nonce_start;
    logic [DATA_WID-1:0]          iv_nonce_end;
    logic                         i_job_vld;
    logic                         o_job_rdy;
    logic                         i_abort;
    logic [WORD_NUM*DATA_WID-1:0] ov_m_data;
    logic                         o_m_data_vld;
    logic                         i_pipe_hold;
    logic                         i_result_vld;
    logic                         i_result_hit;
    logic [DATA_WID-1:0]          ov_found_nonce;
    logic                         o_found_vld;
    logic                         o_job_done;
    logic [INF_W-1:0]             ov_inflight;

    modport master (
        output iv_job_data, iv_nonce_start, iv_nonce_end, i_job_vld, i_abort,
               i_pipe_hold, i_result_vld, i_result_hit,
        input  o_job_rdy, ov_m_data, o_m_data_vld, ov_found_nonce, o_found_vld,
               o_job_done, ov_inflight
    );

    modport slave (
        input  iv_job_data, iv_nonce_start, iv_nonce_end, i_job_vld, i_abort,
               i_pipe_hold, i_result_vld, i_result_hit,
        output o_job_rdy, ov_m_data, o_m_data_vld, ov_found_nonce, o_found_vld,
               o_job_done, ov_inflight
    );
endinterface

// File: rtl/nonce_sweep_scheduler.sv
// Sweeps an inclusive, wrapping nonce range, issuing one padded header block per
// cycle under a credit limit and mapping in-order result returns back to nonces.
module nonce_sweep_scheduler #(
    parameter int WORD_NUM     = 16,
    parameter int DATA_WID     = 32,
    parameter int MAX_INFLIGHT = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nonce_sweep_scheduler_if.slave bus
);
    localparam int INF_W = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                       state_reg;
    logic [3*DATA_WID-1:0]        job_data_reg;
    logic [DATA_WID-1:0]          nonce_end_reg;
    logic [DATA_WID-1:0]          issue_nonce_reg;
    logic [DATA_WID-1:0]          ret_nonce_reg;
    logic                         abort_flag_reg;
    logic [INF_W-1:0]             inflight_reg;
    logic [INF_W-1:0]             inflight_next;
    logic [WORD_NUM*DATA_WID-1:0] m_data_reg;
    logic [WORD_NUM*DATA_WID-1:0] block_next;
    logic                         m_data_vld_reg;
    logic [DATA_WID-1:0]          found_nonce_reg;
    logic                         found_vld_reg;
    logic                         job_done_reg;
    logic                         job_rdy_reg;

    logic ret_ok;
    logic credit_ok;
    logic issue_go;
    logic last_issue;

    // Returns with nothing outstanding are strays (e.g. after a reset) and are dropped.
    assign ret_ok     = bus.i_result_vld && (inflight_reg != '0);
    // A return in the same cycle frees its credit for this cycle's issue decision.
    assign credit_ok  = (inflight_reg < INF_MAX) || ret_ok;
    assign issue_go   = (state_reg == ST_RUN) && !bus.i_pipe_hold && credit_ok && !bus.i_abort;
    assign last_issue = issue_go && (issue_nonce_reg == nonce_end_reg);

    always_comb begin
        inflight_next = inflight_reg;
        if (issue_go && !ret_ok) begin
            inflight_next = inflight_reg + INF_W'(1);
        end else if (!issue_go && ret_ok) begin
            inflight_next = inflight_reg - INF_W'(1);
        end
    end

    // Second header chunk: job words, nonce, SHA-256 pad bit, zeros, 640-bit length.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_NUM; gi++) begin : g_word
            if (gi < 3) begin : g_job
                assign block_next[gi*DATA_WID +: DATA_WID] = job_data_reg[gi*DATA_WID +: DATA_WID];
            end else if (gi == 3) begin : g_nonce
                assign block_next[gi*DATA_WID +: DATA_WID] = issue_nonce_reg;
            end else if (gi == 4) begin : g_pad
                assign block_next[gi*DATA_WID +: DATA_WID] = DATA_WID'(32'h8000_0000);
            end else if (gi == WORD_NUM - 1) begin : g_len
                assign block_next[gi*DATA_WID +: DATA_WID] = DATA_WID'(32'h0000_0280);
            end else begin : g_zero
                assign block_next[gi*DATA_WID +: DATA_WID] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            job_data_reg    <= '0;
            nonce_end_reg   <= '0;
            issue_nonce_reg <= '0;
            ret_nonce_reg   <= '0;
            abort_flag_reg  <= 1'b0;
            inflight_reg    <= '0;
            m_data_reg      <= '0;
            m_data_vld_reg  <= 1'b0;
            found_nonce_reg <= '0;
            found_vld_reg   <= 1'b0;
            job_done_reg    <= 1'b0;
            job_rdy_reg     <= 1'b1;
        end else begin
            m_data_vld_reg <= issue_go;
            found_vld_reg  <= 1'b0;
            job_done_reg   <= 1'b0;
            inflight_reg   <= inflight_next;

            if (issue_go) begin
                m_data_reg      <= block_next;
                issue_nonce_reg <= issue_nonce_reg + DATA_WID'(1);
            end

            if (ret_ok) begin
                ret_nonce_reg <= ret_nonce_reg + DATA_WID'(1);
                if (bus.i_result_hit && !abort_flag_reg) begin
                    found_vld_reg   <= 1'b1;
                    found_nonce_reg <= ret_nonce_reg;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_job_vld) begin
                        job_data_reg    <= bus.iv_job_data;
                        nonce_end_reg   <= bus.iv_nonce_end;
                        issue_nonce_reg <= bus.iv_nonce_start;
                        ret_nonce_reg   <= bus.iv_nonce_start;
                        abort_flag_reg  <= 1'b0;
                        job_rdy_reg     <= 1'b0;
                        state_reg       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.i_abort) begin
                        abort_flag_reg <= 1'b1;
                        state_reg      <= ST_DRAIN;
                    end else if (last_issue) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.i_abort) begin
                        abort_flag_reg <= 1'b1;
                    end
                    if (inflight_next == '0) begin
                        job_done_reg <= 1'b1;
                        job_rdy_reg  <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    job_rdy_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_job_rdy      = job_rdy_reg;
    assign bus.ov_m_data      = m_data_reg;
    assign bus.o_m_data_vld   = m_data_vld_reg;
    assign bus.ov_found_nonce = found_nonce_reg;
    assign bus.o_found_vld    = found_vld_reg;
    assign bus.o_job_done     = job_done_reg;
    assign bus.ov_inflight    = inflight_reg;
endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Scoreboard bench: a latency/credit pipeline model returns results, and a
// separate monitor checks blocks, hit reports and job completion.
module tb_nonce_sweep_scheduler;
    localparam int WN = 16;
    localparam int DW = 32;
    localparam int MI = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nonce_sweep_scheduler_if #(.WORD_NUM(WN), .DATA_WID(DW), .MAX_INFLIGHT(MI)) bus ();

    nonce_sweep_scheduler #(.WORD_NUM(WN), .DATA_WID(DW), .MAX_INFLIGHT(MI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [31:0] exp_nonce_q[$];
    logic [31:0] exp_found_q[$];
    logic [95:0] job_words;
    logic [31:0] job_start;
    int          blocks_this_job = 0;
    int          done_cnt = 0;
    int unsigned accept_cyc = 0;
    bit          lat_check = 0;
    bit          first_blk = 0;
    bit          tb_aborted = 0;

    // pipeline model controls
    int unsigned pipe_q[$];
    int          lat = 4;
    bit          ret_en = 1;
    bit          ret_rand = 0;
    bit          one_ret = 0;
    bit          stray = 0;
    bit          hold_rand = 0;
    int          hit_idx = -1;
    int          ret_idx = 0;
    int          model_inf = 0;
    bit          pend = 0;
    int unsigned last_ret_cyc = 0;

    function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pipeline model: fixed latency, in-order returns, credit count from first principles.
    initial begin
        bus.i_result_vld = 1'b0;
        bus.i_result_hit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                model_inf = 0;
                pend = 0;
                pipe_q.delete();
                bus.i_result_vld = 1'b0;
                bus.i_result_hit = 1'b0;
            end else begin
                if (pend) model_inf--;
                pend = 0;
                if (bus.o_m_data_vld) begin
                    model_inf++;
                    pipe_q.push_back(cyc);
                end
                chk("inflight", bus.ov_inflight, model_inf);
                bus.i_result_vld = 1'b0;
                bus.i_result_hit = 1'b0;
                if (stray) begin
                    bus.i_result_vld = 1'b1;
                    bus.i_result_hit = 1'b1;
                end else if (pipe_q.size() > 0 && (ret_en || one_ret) &&
                             (cyc - pipe_q[0]) >= lat && (!ret_rand || $urandom_range(0, 1) == 1)) begin
                    one_ret = 0;
                    void'(pipe_q.pop_front());
                    bus.i_result_vld = 1'b1;
                    bus.i_result_hit = (ret_idx == hit_idx);
                    if (ret_idx == hit_idx && !tb_aborted)
                        exp_found_q.push_back(job_start + 32'(ret_idx));
                    ret_idx++;
                end
                if (bus.i_result_vld && model_inf > 0) begin
                    pend = 1;
                    last_ret_cyc = cyc;
                end
            end
        end
    end

    // Random backpressure; a held cycle must not produce a block next cycle.
    initial begin
        bus.i_pipe_hold = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && bus.i_pipe_hold) chk("hold_blocks_issue", bus.o_m_data_vld, 0);
            bus.i_pipe_hold = hold_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    // Monitor
    initial begin
        logic [31:0]  n;
        logic [511:0] exp_blk;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (bus.o_m_data_vld) begin
                    $display("[%0d] block nonce=%h", cyc, bus.ov_m_data[127:96]);
                    if (exp_nonce_q.size() == 0) begin
                        chk("extra_block", bus.ov_m_data[127:96], 0);
                        if (bus.ov_m_data[127:96] == 0) chk("extra_block_present", 1, 0);
                    end else begin
                        n = exp_nonce_q.pop_front();
                        exp_blk = {32'h0000_0280, 320'h0, 32'h8000_0000, n, job_words};
                        chk("block", bus.ov_m_data, exp_blk);
                    end
                    if (first_blk && lat_check) chk("first_latency", cyc - accept_cyc, 2);
                    first_blk = 0;
                    blocks_this_job++;
                end
                if (bus.o_found_vld) begin
                    $display("[%0d] found nonce=%h", cyc, bus.ov_found_nonce);
                    if (exp_found_q.size() == 0) chk("unexpected_found", 1, 0);
                    else chk("found_nonce", bus.ov_found_nonce, exp_found_q.pop_front());
                end
                if (bus.o_job_done) begin
                    $display("[%0d] job done blocks=%0d", cyc, blocks_this_job);
                    chk("done_inflight", bus.ov_inflight, 0);
                    chk("done_rdy", bus.o_job_rdy, 1);
                    chk("done_after_last_ret", cyc, last_ret_cyc + 1);
                    if (!tb_aborted) chk("blocks_left", exp_nonce_q.size(), 0);
                    chk("found_left", exp_found_q.size(), 0);
                    chk("pipe_empty", pipe_q.size(), 0);
                    done_cnt++;
                end
            end
        end
    end

    task automatic start_job(input logic [31:0] w0, w1, w2, s, e, input bit lc);
        logic [31:0] cnt;
        int g = 0;
        while (!bus.o_job_rdy && g < 3000) begin
            tick(1);
            g++;
        end
        if (!bus.o_job_rdy) begin
            $display("FAIL job_rdy_timeout: got 0 expected 1");
            $fatal(1, "scheduler never became ready");
        end
        job_words = {w2, w1, w0};
        job_start = s;
        exp_nonce_q.delete();
        exp_found_q.delete();
        cnt = e - s + 32'd1;
        for (int unsigned i = 0; i < cnt; i++) exp_nonce_q.push_back(s + 32'(i));
        blocks_this_job = 0;
        first_blk = 1;
        ret_idx = 0;
        tb_aborted = 0;
        lat_check = lc;
        accept_cyc = cyc;
        bus.iv_job_data = {w2, w1, w0};
        bus.iv_nonce_start = s;
        bus.iv_nonce_end = e;
        bus.i_job_vld = 1'b1;
        tick(1);
        bus.i_job_vld = 1'b0;
    endtask

    task automatic wait_done();
        int t0 = done_cnt;
        int k = 0;
        while (done_cnt == t0 && k < 5000) begin
            tick(1);
            k++;
        end
        chk("job_done_seen", done_cnt - t0, 1);
        tick(3);
        chk("single_job_done", done_cnt - t0, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_job_rdy", bus.o_job_rdy, 1);
        chk("rst_m_vld", bus.o_m_data_vld, 0);
        chk("rst_m_data", bus.ov_m_data, 0);
        chk("rst_found_vld", bus.o_found_vld, 0);
        chk("rst_found_nonce", bus.ov_found_nonce, 0);
        chk("rst_job_done", bus.o_job_done, 0);
        chk("rst_inflight", bus.ov_inflight, 0);
    endtask

    initial begin
        int n;
        int k;
        logic [31:0] rs;
        bus.iv_job_data = '0;
        bus.iv_nonce_start = '0;
        bus.iv_nonce_end = '0;
        bus.i_job_vld = 1'b0;
        bus.i_abort = 1'b0;
        tick(3);
        chk_reset_vals();
        rst_n = 1'b1;
        tick(2);

        // basic and hit jobs through a 64-cycle pipeline
        lat = 64;
        start_job(32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'd5, 32'd8, 1);
        wait_done();
        chk("basic_blocks", blocks_this_job, 4);
        hit_idx = 2;
        start_job(32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'd5, 32'd8, 1);
        wait_done();
        hit_idx = -1;

        // wrap through FFFF_FFFF and single-nonce job
        lat = 5;
        start_job(32'h1234_5678, 32'h5F00_0001, 32'h1703_2A4B, 32'hFFFF_FFFE, 32'h0000_0001, 1);
        wait_done();
        chk("wrap_blocks", blocks_this_job, 4);
        lat = 1;
        hit_idx = 0;
        start_job(32'h0BAD_F00D, 32'h0000_0011, 32'h0000_0022, 32'd9, 32'd9, 1);
        wait_done();
        chk("single_blocks", blocks_this_job, 1);
        hit_idx = -1;

        // random backpressure and random return timing
        lat = 3;
        hold_rand = 1;
        ret_rand = 1;
        rs = $urandom;
        hit_idx = $urandom_range(0, 29);
        start_job($urandom, $urandom, $urandom, rs, rs + 32'd29, 0);
        wait_done();
        chk("hold_blocks", blocks_this_job, 30);
        hold_rand = 0;
        ret_rand = 0;
        hit_idx = -1;

        // credit limit: stall at MAX_INFLIGHT, one return lets one more through
        lat = 2;
        ret_en = 0;
        start_job(32'h1, 32'h2, 32'h3, 32'd100, 32'd199, 1);
        tick(20);
        chk("credit_stall_issues", blocks_this_job, MI);
        one_ret = 1;
        tick(5);
        chk("credit_one_more", blocks_this_job, MI + 1);
        bus.i_abort = 1'b1;
        tb_aborted = 1;
        tick(1);
        bus.i_abort = 1'b0;
        ret_en = 1;
        wait_done();
        chk("credit_total", blocks_this_job, MI + 1);

        // abort after 10 issues; hit on 10th return must stay silent
        lat = 3;
        hit_idx = 9;
        start_job(32'h4, 32'h5, 32'h6, 32'd1000, 32'd2000, 1);
        n = 0;
        k = 0;
        while (n < 10 && k < 1000) begin
            tick(1);
            k++;
            if (bus.o_m_data_vld) n++;
        end
        bus.i_abort = 1'b1;
        tb_aborted = 1;
        tick(1);
        bus.i_abort = 1'b0;
        wait_done();
        chk("abort_blocks", blocks_this_job, 10);
        chk("abort_rdy_after", bus.o_job_rdy, 1);
        hit_idx = -1;

        // asynchronous reset in the middle of RUN, then stray returns
        lat = 4;
        start_job(32'h7, 32'h8, 32'h9, 32'd500, 32'd600, 1);
        tick(15);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        exp_nonce_q.delete();
        exp_found_q.delete();
        ret_en = 0;
        tick(2);
        rst_n = 1'b1;
        stray = 1;
        tick(5);
        stray = 0;
        tick(3);
        chk("stray_inflight", bus.ov_inflight, 0);
        chk("stray_rdy", bus.o_job_rdy, 1);
        ret_en = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nonce_sweep_scheduler.md
# nonce_sweep_scheduler

Job sequencer in front of the double-SHA256 pipeline. It accepts one mining job (second 64-byte header chunk fields plus a nonce range) and issues one padded 512-bit message block per cycle into the message-expansion/compression chain, incrementing the nonce each time. It tracks in-flight blocks with a credit counter and reconstructs the nonce of each returned result from in-order returns. It reports hits and signals job completion once the pipeline has drained.

## Interface
- WORD_NUM, 16, words per message block
- DATA_WID, 32, word width
- MAX_INFLIGHT, 128, credit limit; must be ≥ pipeline depth, power of two not required
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, asynchronous and active-low
- iv_job_data  in  3*DATA_WID  word0 merkle-root tail, word1 ntime, word2 nbits, word k at [DATA_WID*k +: DATA_WID]
- iv_nonce_start  in  DATA_WID  first nonce, inclusive
- iv_nonce_end  in  DATA_WID  last nonce, inclusive
- i_job_vld  in  1  job offered
- o_job_rdy  out  1  job can be accepted (high only in IDLE)
- i_abort  in  1  stop the current job
- ov_m_data  out  WORD_NUM*DATA_WID  message block to pipeline
- o_m_data_vld  out  1  ov_m_data valid this cycle
- i_pipe_hold  in  1  pipeline cannot take a block this cycle
- i_result_vld  in  1  one result returned, in issue order
- i_result_hit  in  1  returned result meets target (qualified by i_result_vld)
- ov_found_nonce  out  DATA_WID  nonce of hit
- o_found_vld  out  1  one-cycle pulse with ov_found_nonce
- o_job_done  out  1  one-cycle pulse, job fully drained
- ov_inflight  out  clog2(MAX_INFLIGHT)+1  current in-flight count

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: o_job_rdy=1. On i_job_vld, the job fields and range are registered. issue_nonce<=start, ret_nonce<=start, abort_flag<=0. Next state is RUN.
- Block layout (word k at [32k+:32]): w0..w2 = job words, w3 = issue_nonce, w4 = 32'h8000_0000, w5..w14 = 0, w15 = 32'h0000_0280. Byte order is as supplied; no swapping.
- RUN issue condition: !i_pipe_hold && ov_inflight < MAX_INFLIGHT && !i_abort.
  - When met, the block is issued (registered output) and issue_nonce increments modulo 2^32.
  - If the issued nonce == end, next state is DRAIN.
- Range is inclusive and wraps: start==end gives 1 block; start==end+1 gives 2^32 blocks; start>end sweeps through 32'hFFFF_FFFF to 0.
- i_abort in RUN: no issue that cycle, abort_flag<=1, next state is DRAIN. i_abort in IDLE/DRAIN: sets abort_flag only in DRAIN, otherwise ignored.
- DRAIN: no issue. When ov_inflight==0 (including results of this cycle), o_job_done pulses and next state is IDLE.
- Credits: ov_inflight +1 per issue, −1 per i_result_vld, both in the same cycle gives net 0. i_result_vld at ov_inflight==0 is ignored: no decrement, no ret_nonce change.
- Returns: each counted i_result_vld advances ret_nonce by 1. If i_result_hit && !abort_flag, the next cycle gives o_found_vld=1 and ov_found_nonce=ret_nonce before the increment. Hits after abort are counted but not reported.
- A new job is never accepted while results are outstanding; IDLE implies ov_inflight==0.

## Timing
- Reset (async assert, sync release): state IDLE, o_job_rdy=1, o_m_data_vld=0, ov_m_data=0, o_found_vld=0, ov_found_nonce=0, o_job_done=0, ov_inflight=0.
- Reset mid-job: everything is discarded immediately; results arriving later are ignored per the inflight==0 rule.
- Acceptance in cycle T: the first o_m_data_vld is in T+2 (T+1 enters RUN and registers the issue), given no hold.
- Sustained throughput is 1 block/cycle. i_pipe_hold in cycle t gives o_m_data_vld=0 in t+1, and the nonce is not advanced.
- Hit report latency: 1 cycle after i_result_vld.
- o_job_done: 1 cycle after the cycle in which the last result returns, or in which DRAIN is entered with inflight already 0.
- Credit-full: while inflight==MAX_INFLIGHT there is no issue. A return in that cycle allows an issue in the same cycle's decision.

## Test plan
- Basic job: words {A,B,C}, start=5, end=8, pipeline model latency 64 -> 4 blocks with w3=5,6,7,8, w4=8000_0000, w15=0000_0280; one o_job_done; ov_inflight ends at 0.
- Hit: same job with i_result_hit on the 3rd return -> o_found_vld once with nonce 7.
- Wrap: start=FFFF_FFFE, end=1 -> 4 blocks with nonces FFFF_FFFE, FFFF_FFFF, 0, 1; single-nonce job start=end=9 -> 1 block.
- Backpressure/credits: MAX_INFLIGHT=4, no returns for 20 cycles -> exactly 4 issues, then stall; one return -> one further issue; random i_pipe_hold -> no nonce skipped or duplicated.
- Abort: abort after 10 issues with a hit returning later -> issue stops the next cycle, no o_found_vld, o_job_done after the 10th return, o_job_rdy=1 afterward.
- Async reset mid-RUN, then stray i_result_vld -> outputs at reset values instantly, ov_inflight stays 0, no found pulse.
